// File: rtl/data_mem_responder.sv
// Load/store memory responder: one request at a time, programmable wait states,
// byte-lane writes and sign/zero-extended reads on an internal word RAM.
module data_mem_responder #(
  parameter int AddressWidth = 10,
  parameter int WaitStates   = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [AddressWidth-1:0] req_addr_i,
  input  logic [31:0]             req_wdata_i,
  input  logic [2:0]              req_funct3_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [31:0]             rsp_rdata_o,
  output logic                    rsp_err_o
);
  localparam int Words = 2 ** (AddressWidth - 2);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q;
  logic [AddressWidth-1:0] addr_q;
  logic [31:0]             wdata_q;
  logic [2:0]              f3_q;
  logic [31:0]             rdata_q;
  logic                    err_q;

  logic [31:0] mem [Words];

  logic                    access;
  logic                    err_c;
  logic [AddressWidth-3:0] word_idx;
  logic [1:0]              lane;
  logic [31:0]             rd_word;
  logic [7:0]              rd_byte;
  logic [15:0]             rd_half;
  logic [31:0]             load_data;
  logic [3:0]              be;
  logic [31:0]             wd;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, before the reset edge lands.
  always_comb begin
    req_ready_o = (state_q == IDLE) && !rst_i;
    rsp_valid_o = (state_q == RESP) && !rst_i;
    rsp_rdata_o = rst_i ? 32'd0 : rdata_q;
    rsp_err_o   = !rst_i && err_q;
  end

  assign access   = (state_q == BUSY) && (cnt_q == 4'd0);
  assign word_idx = addr_q[AddressWidth-1:2];
  assign lane     = addr_q[1:0];

  always_comb begin
    err_c = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111) || (we_q && f3_q[2]);
    if ((f3_q[1:0] == 2'b01) && lane[0])         err_c = 1'b1;
    if ((f3_q[1:0] == 2'b10) && (lane != 2'b00)) err_c = 1'b1;
  end

  always_comb begin
    rd_word   = mem[word_idx];
    rd_byte   = rd_word[{lane, 3'b000} +: 8];
    rd_half   = rd_word[{lane[1], 4'b0000} +: 16];
    load_data = 32'd0;
    case (f3_q)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {24'd0, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'd0, rd_half};
      3'b010:  load_data = rd_word;
      default: load_data = 32'd0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables pick the right copy.
  always_comb begin
    be = 4'b0000;
    wd = 32'd0;
    case (f3_q[1:0])
      2'b00: begin be = 4'b0001 << lane;                    wd = {4{wdata_q[7:0]}};  end
      2'b01: begin be = lane[1] ? 4'b1100 : 4'b0011;        wd = {2{wdata_q[15:0]}}; end
      2'b10: begin be = 4'b1111;                            wd = wdata_q;            end
      default: begin be = 4'b0000;                          wd = 32'd0;              end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && access && we_q && !err_c) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[word_idx][8*k +: 8] <= wd[8*k +: 8];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && req_valid_i) cnt_d = 4'(WaitStates);
    else if (state_q == BUSY && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == IDLE && req_valid_i) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        f3_q    <= req_funct3_i;
      end
      if (access) begin
        err_q   <= err_c;
        rdata_q <= (we_q || err_c) ? 32'd0 : load_data;
      end
    end
  end
endmodule
